// File: rtl/trig_delay_queue.sv
// trig_delay_queue
// ----------------
// Multi-slot trigger delay generator. Every rising edge of trig_in that is
// accepted claims a free slot, which counts down its own latched delay and
// then fires. Any fire (re)starts an output pulse of programmable width.
// Up to DEPTH triggers may be in flight at the same time.
//
// Ports:
//   clk       in   single clock domain
//   rst       in   asynchronous, active-high reset
//   trig_in   in   trigger request, rising edges only
//   enable    in   1 = accept new edges; in-flight slots always continue
//   flush     in   synchronous clear of all slots and of the output pulse
//   delay     in   DELAY_W delay in clocks, latched when the edge is accepted
//   width     in   WIDTH_W pulse width in clocks, latched at fire (0 acts as 1)
//   clr_ovf   in   synchronous clear of overflow
//   trig_out  out  registered delayed trigger pulse
//   pending   out  number of occupied slots
//   overflow  out  sticky flag: an edge was dropped with all slots busy
//   fire_cnt  out  number of cycles in which at least one slot fired (wraps)
module trig_delay_queue #(
    parameter int DELAY_W = 16,
    parameter int WIDTH_W = 8,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         trig_in,
    input  logic                         enable,
    input  logic                         flush,
    input  logic [DELAY_W-1:0]           delay,
    input  logic [WIDTH_W-1:0]           width,
    input  logic                         clr_ovf,
    output logic                         trig_out,
    output logic [$clog2(DEPTH+1)-1:0]   pending,
    output logic                         overflow,
    output logic [CNT_W-1:0]             fire_cnt
);

    localparam int PEND_W = $clog2(DEPTH + 1);

    logic                trig_d_q,   trig_d_d;
    logic [DEPTH-1:0]    busy_q,     busy_d;
    logic [DELAY_W-1:0]  cnt_q [DEPTH];
    logic [DELAY_W-1:0]  cnt_d [DEPTH];
    logic [WIDTH_W-1:0]  wcnt_q,     wcnt_d;
    logic                trig_out_q, trig_out_d;
    logic [PEND_W-1:0]   pending_q,  pending_d;
    logic                overflow_q, overflow_d;
    logic [CNT_W-1:0]    fire_cnt_q, fire_cnt_d;

    logic                trig_edge;
    logic [DEPTH-1:0]    fire;
    logic                any_fire;
    logic                found;
    logic                drop;

    always_comb begin
        trig_d_d   = trig_in;
        trig_edge  = trig_in & ~trig_d_q;

        fire       = '0;
        any_fire   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            fire[i]  = busy_q[i] && (cnt_q[i] == '0);
            any_fire = any_fire | fire[i];
        end

        busy_d     = busy_q;
        cnt_d      = cnt_q;
        wcnt_d     = wcnt_q;
        trig_out_d = trig_out_q;
        overflow_d = overflow_q;
        fire_cnt_d = fire_cnt_q;
        found      = 1'b0;
        drop       = 1'b0;

        if (flush) begin
            // Flush wins over fires and edges; the counters of record
            // (overflow, fire_cnt) are left untouched.
            busy_d     = '0;
            wcnt_d     = '0;
            trig_out_d = 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (fire[i]) begin
                    busy_d[i] = 1'b0;
                end else if (busy_q[i]) begin
                    cnt_d[i] = cnt_q[i] - DELAY_W'(1);
                end
            end

            // Slot search uses the pre-edge busy vector, so a slot that
            // fires this cycle cannot be claimed by the same edge.
            if (trig_edge && enable) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (!busy_q[i] && !found) begin
                        busy_d[i] = 1'b1;
                        cnt_d[i]  = delay;
                        found     = 1'b1;
                    end
                end
                drop = ~found;
            end

            // Any fire reloads the width counter, so overlapping pulses
            // merge into one contiguous high period.
            if (any_fire) begin
                wcnt_d     = (width == '0) ? WIDTH_W'(1) : width;
                trig_out_d = 1'b1;
                fire_cnt_d = fire_cnt_q + CNT_W'(1);
            end else if (wcnt_q > WIDTH_W'(1)) begin
                wcnt_d = wcnt_q - WIDTH_W'(1);
            end else if (wcnt_q == WIDTH_W'(1)) begin
                wcnt_d     = '0;
                trig_out_d = 1'b0;
            end

            if (drop) begin
                overflow_d = 1'b1;
            end else if (clr_ovf) begin
                overflow_d = 1'b0;
            end
        end

        pending_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pending_d = pending_d + PEND_W'(busy_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_d_q   <= 1'b0;
            busy_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= '0;
            end
            wcnt_q     <= '0;
            trig_out_q <= 1'b0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            fire_cnt_q <= '0;
        end else begin
            trig_d_q   <= trig_d_d;
            busy_q     <= busy_d;
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            wcnt_q     <= wcnt_d;
            trig_out_q <= trig_out_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            fire_cnt_q <= fire_cnt_d;
        end
    end

    assign trig_out = trig_out_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;
    assign fire_cnt = fire_cnt_q;

endmodule
